// File: rtl/rx_uart_pkg.sv
// rtl/rx_uart_pkg.sv - shared types and framing constants for the 8N1 UART receiver
package rx_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam int OVERSAMPLE = 16;
    localparam int HALF_BIT   = 8;
    localparam int DATA_BITS  = 8;

endpackage

// File: rtl/rx_uart_if.sv
// rtl/rx_uart_if.sv - host-side receive FIFO port: read strobe, head byte and occupancy flags
interface rx_uart_if;
    logic       read;
    logic [7:0] dataOut;
    logic       dataPresent;
    logic       halfFull;
    logic       full;

    modport master (output read, input dataOut, dataPresent, halfFull, full);
    modport slave  (input read, output dataOut, dataPresent, halfFull, full);
endinterface

// File: rtl/rx_uart_fifo.sv
// rtl/rx_uart_fifo.sv - 8-bit first-word-fall-through FIFO with count-based registered flags
module rx_uart_fifo #(
    parameter int LOG2_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_i,
    input  logic [7:0] wr_data_i,
    input  logic       rd_i,
    output logic [7:0] data_o,
    output logic       present_o,
    output logic       half_full_o,
    output logic       full_o
);
    localparam int DEPTH = 2 ** LOG2_DEPTH;
    localparam logic [LOG2_DEPTH:0] ONE_CNT  = (LOG2_DEPTH + 1)'(1);
    localparam logic [LOG2_DEPTH:0] HALF_CNT = (LOG2_DEPTH + 1)'(DEPTH / 2);
    localparam logic [LOG2_DEPTH:0] FULL_CNT = (LOG2_DEPTH + 1)'(DEPTH);
    localparam logic [LOG2_DEPTH-1:0] ONE_PTR = (LOG2_DEPTH)'(1);

    logic [7:0]            mem_q [DEPTH];
    logic [LOG2_DEPTH-1:0] wr_ptr_q, rd_ptr_q;
    logic [LOG2_DEPTH:0]   count_q, count_d;
    logic                  present_q, half_q, full_q;
    logic                  do_wr, do_rd;

    // A read frees a slot in the same cycle, so a write to a full FIFO succeeds if paired with a read.
    always_comb begin
        do_rd   = rd_i && (count_q != '0);
        do_wr   = wr_i && ((count_q != FULL_CNT) || do_rd);
        count_d = count_q;
        if (do_wr && !do_rd) begin
            count_d = count_q + ONE_CNT;
        end else if (!do_wr && do_rd) begin
            count_d = count_q - ONE_CNT;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            present_q <= 1'b0;
            half_q    <= 1'b0;
            full_q    <= 1'b0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + ONE_PTR;
            if (do_rd) rd_ptr_q <= rd_ptr_q + ONE_PTR;
            count_q   <= count_d;
            present_q <= (count_d != '0);
            half_q    <= (count_d >= HALF_CNT);
            full_q    <= (count_d == FULL_CNT);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign data_o      = present_q ? mem_q[rd_ptr_q] : 8'h00;
    assign present_o   = present_q;
    assign half_full_o = half_q;
    assign full_o      = full_q;
endmodule

// File: rtl/rx_uart.sv
// rtl/rx_uart.sv - 16x oversampling 8N1 deframer feeding a FWFT FIFO; RX_UART_FRAME_CHECK_EN drops bad-stop frames
module rx_uart
    import rx_uart_pkg::*;
#(
    parameter int LOG2_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         x16BaudStrobe,
    input  logic         serialIn,
    rx_uart_if.slave     host
);
    localparam logic [3:0] LAST_STROBE = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] MID_STROBE  = 4'(HALF_BIT - 1);
    localparam logic [2:0] LAST_BIT    = 3'(DATA_BITS - 1);

    logic       sync1_q, sync2_q;
    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [7:0] shift_q, shift_d;
    logic       armed_q, armed_d;
    logic       wr_q, wr_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            armed_q   <= 1'b1;
            wr_q      <= 1'b0;
        end else begin
            sync1_q   <= serialIn;
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            armed_q   <= armed_d;
            wr_q      <= wr_d;
        end
    end

    // armed_q only drops after a framing error; the line must return high before a new start is accepted.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        armed_d   = armed_q;
        wr_d      = 1'b0;
        if (x16BaudStrobe) begin
            unique case (state_q)
                IDLE: begin
                    if (sync2_q) begin
                        armed_d = 1'b1;
                    end else if (armed_q) begin
                        state_d = START;
                        cnt_d   = '0;
                    end
                end
                START: begin
                    if (cnt_q == MID_STROBE) begin
                        cnt_d     = '0;
                        bit_idx_d = '0;
                        state_d   = sync2_q ? IDLE : DATA;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                DATA: begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == LAST_STROBE) begin
                        shift_d[bit_idx_q] = sync2_q;
                        bit_idx_d          = bit_idx_q + 3'd1;
                        if (bit_idx_q == LAST_BIT) state_d = STOP;
                    end
                end
                STOP: begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == LAST_STROBE) begin
                        state_d = IDLE;
`ifdef RX_UART_FRAME_CHECK_EN
                        wr_d    = sync2_q;
                        armed_d = sync2_q;
`else
                        wr_d    = 1'b1;
`endif
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    rx_uart_fifo #(.LOG2_DEPTH(LOG2_DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .wr_i        (wr_q),
        .wr_data_i   (shift_q),
        .rd_i        (host.read),
        .data_o      (host.dataOut),
        .present_o   (host.dataPresent),
        .half_full_o (host.halfFull),
        .full_o      (host.full)
    );
endmodule

// File: tb/tb_rx_uart.sv
// tb/tb_rx_uart.sv - directed bench for rx_uart with a queue model of the receive FIFO
module tb_rx_uart;
    import rx_uart_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic strobe = 1'b0;
    logic serial_in = 1'b1;
    rx_uart_if host ();

    rx_uart #(.LOG2_DEPTH(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .x16BaudStrobe (strobe),
        .serialIn      (serial_in),
        .host          (host)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            repeat (7) @(negedge clk);
            strobe = 1'b1;
            @(negedge clk);
            strobe = 1'b0;
        end
    end

    logic [7:0] q[$];
    bit         check_en = 1'b0;
    int         vectors = 0;
    int         miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("m_dataPresent", 32'(host.dataPresent), 32'(q.size() != 0));
            chk("m_dataOut", 32'(host.dataOut), (q.size() != 0) ? 32'(q[0]) : 32'h0);
            chk("m_halfFull", 32'(host.halfFull), 32'(q.size() >= 8));
            chk("m_full", 32'(host.full), 32'(q.size() == 16));
        end
    end

    task automatic tx_bit(input logic v);
        serial_in = v;
        repeat (128) @(posedge clk);
        #1;
    endtask

    task automatic do_read();
        logic [7:0] tmp;
        @(negedge clk);
        host.read = 1'b1;
        @(posedge clk);
        #1;
        host.read = 1'b0;
        if (q.size() != 0) tmp = q.pop_front();
    endtask

    task automatic send(input logic [7:0] b, input logic stop_v, input bit rd_on_wr);
        bit         fired;
        bit         accept;
        logic [7:0] tmp;
        tx_bit(1'b0);
        for (int i = 0; i < 8; i++) tx_bit(b[i]);
        check_en = 1'b0;
        if (rd_on_wr) begin
            fired = 1'b0;
            serial_in = stop_v;
            for (int c = 0; c < 128; c++) begin
                @(negedge clk);
                host.read = !fired && dut.wr_q;
                if (host.read) fired = 1'b1;
                @(posedge clk);
            end
            #1;
            host.read = 1'b0;
            chk("rd_on_wr_fired", 32'(fired), 32'h1);
            if (q.size() != 0) tmp = q.pop_front();
        end else begin
            tx_bit(stop_v);
        end
        accept = 1'b1;
`ifdef RX_UART_FRAME_CHECK_EN
        accept = stop_v;
`endif
        if (accept && q.size() < 16) q.push_back(b);
        check_en = 1'b1;
        if (!stop_v) tx_bit(1'b1);
    endtask

    initial begin
        logic [7:0] exp_tail [16];
        host.read = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("rst_dataOut", 32'(host.dataOut), 32'h00);
        chk("rst_dataPresent", 32'(host.dataPresent), 32'h0);
        chk("rst_halfFull", 32'(host.halfFull), 32'h0);
        chk("rst_full", 32'(host.full), 32'h0);
        rst = 1'b1;
        check_en = 1'b1;
        tx_bit(1'b1);

        send(8'hA5, 1'b1, 1'b0);
        chk("a5_present", 32'(host.dataPresent), 32'h1);
        chk("a5_data", 32'(host.dataOut), 32'hA5);
        do_read();
        chk("a5_drained", 32'(host.dataPresent), 32'h0);

        serial_in = 1'b0;
        repeat (32) @(posedge clk);
        #1;
        tx_bit(1'b1);
        tx_bit(1'b1);
        chk("glitch_present", 32'(host.dataPresent), 32'h0);
        chk("glitch_idle", 32'(dut.state_q), 32'(IDLE));

        do_read();
        chk("empty_read_present", 32'(host.dataPresent), 32'h0);

        send(8'h77, 1'b1, 1'b1);
        chk("empty_rw_present", 32'(host.dataPresent), 32'h1);
        chk("empty_rw_data", 32'(host.dataOut), 32'h77);
        do_read();

        for (int i = 0; i < 16; i++) begin
            send(8'(i), 1'b1, 1'b0);
            chk("fill_halfFull", 32'(host.halfFull), 32'(i >= 7));
            chk("fill_full", 32'(host.full), 32'(i == 15));
        end
        send(8'hFF, 1'b1, 1'b0);
        chk("drop_full", 32'(host.full), 32'h1);
        chk("drop_head", 32'(host.dataOut), 32'h00);

        send(8'hEE, 1'b1, 1'b1);
        chk("full_rw_full", 32'(host.full), 32'h1);
        chk("full_rw_head", 32'(host.dataOut), 32'h01);

        for (int i = 0; i < 15; i++) exp_tail[i] = 8'(i + 1);
        exp_tail[15] = 8'hEE;
        for (int i = 0; i < 16; i++) begin
            chk("drain_order", 32'(host.dataOut), 32'(exp_tail[i]));
            do_read();
        end
        chk("drain_empty", 32'(host.dataPresent), 32'h0);

        send(8'h3C, 1'b0, 1'b0);
`ifdef RX_UART_FRAME_CHECK_EN
        chk("badstop_present", 32'(host.dataPresent), 32'h0);
`else
        chk("badstop_present", 32'(host.dataPresent), 32'h1);
        chk("badstop_data", 32'(host.dataOut), 32'h3C);
        do_read();
`endif
        send(8'h5A, 1'b1, 1'b0);
        chk("after_bad_data", 32'(host.dataOut), 32'h5A);
        do_read();

        tx_bit(1'b0);
        tx_bit(1'b1);
        tx_bit(1'b0);
        tx_bit(1'b0);
        check_en = 1'b0;
        rst = 1'b0;
        serial_in = 1'b1;
        q.delete();
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        check_en = 1'b1;
        tx_bit(1'b1);
        tx_bit(1'b1);
        chk("abort_present", 32'(host.dataPresent), 32'h0);
        chk("abort_idle", 32'(dut.state_q), 32'(IDLE));
        send(8'h42, 1'b1, 1'b0);
        chk("post_abort_data", 32'(host.dataOut), 32'h42);
        do_read();
        repeat (4) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
